// File: rtl/pipeline_pkg.sv
// Shared definitions for the core's pipeline register slices.
package pipeline_pkg;

  localparam int unsigned OccupancyWidth = 2;
  localparam int unsigned SkidDepth      = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipeline_skid_state_e;

  function automatic logic [OccupancyWidth-1:0] skid_occupancy(pipeline_skid_state_e st);
    unique case (st)
      EMPTY:   skid_occupancy = 2'd0;
      ONE:     skid_occupancy = 2'd1;
      FULL:    skid_occupancy = 2'd2;
      default: skid_occupancy = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_skid.sv
// Two-entry valid/ready slice with a registered ready; the skid entry catches the
// beat already in flight when downstream stalls.
module pipeline_skid
  import pipeline_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic                      clear_i,
  input  logic [DATAWIDTH-1:0]      data_in_i,
  input  logic                      data_in_valid_i,
  output logic                      data_in_ready_o,
  output logic [DATAWIDTH-1:0]      data_out_o,
  output logic                      data_out_valid_o,
  input  logic                      data_out_ready_i,
  output logic [OccupancyWidth-1:0] occupancy_o
);

`ifdef SIMULATION
  initial begin
    if (DATAWIDTH < 1) $fatal(1, "pipeline_skid: DATAWIDTH must be at least 1");
  end
`endif

  pipeline_skid_state_e state_q, state_d;
  logic                 ready_q, ready_d;
  logic [DATAWIDTH-1:0] main_q, main_d;
  logic [DATAWIDTH-1:0] skid_q, skid_d;
  logic                 in_fire, out_fire;

  // Both outputs are masked by clear and reset, so neither fire can happen then.
  assign data_in_ready_o  = ready_q & ~clear_i & arst_ni;
  assign data_out_valid_o = (state_q != EMPTY) & ~clear_i & arst_ni;
  assign data_out_o       = main_q;
  assign occupancy_o      = skid_occupancy(state_q);

  assign in_fire  = data_in_valid_i & data_in_ready_o;
  assign out_fire = data_out_valid_o & data_out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = data_in_i;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = data_in_i;
        end else if (in_fire) begin
          skid_d  = data_in_i;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (clear_i) state_d = EMPTY;
    // Ready depends only on registered state, never on this cycle's data_out_ready_i.
    ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
